conv_encoder_tx: RTL and testbench
==================================

CONV_ENCODER_TX -- requirements
Module: conv_encoder_tx

Interface
REQ-001: The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002: Ports, in order (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dvalid_i  in  1  input byte valid.
- data_i  in  8  input byte; bit 0 is encoded first.
- ready_o  out  1  input FIFO can accept a byte.
- flush_i  in  1  one-cycle request to return the encoder shift state to 00.
- busy_i  in  1  downstream Viterbi decoder busy; no packet is issued while it is high.
- data_o  out  16  encoded packet.
- dvalid_o  out  1  one-cycle packet strobe.
- fifo_level_o  out  3  input FIFO occupancy, range 0..4.

Function
REQ-003: Input FIFO:
- Depth 4 bytes.
- ready_o = (fifo_level_o != 4), combinational from the registered level.
- A byte is pushed on an edge where dvalid_i && ready_o.
- dvalid_i while ready_o is low SHALL be ignored; the byte is dropped and the level is unchanged.
REQ-004: A push and a pop on the same edge SHALL leave the level unchanged. Read and write pointers are 2 bits and wrap 3->0.
REQ-005: The FSM SHALL have three states: IDLE, ENCODE, SEND.
REQ-006: IDLE:
- If the FIFO is non-empty, the FSM pops the head byte into an 8-bit shift register, clears the 3-bit bit counter and goes to ENCODE.
- Otherwise it stays in IDLE.
REQ-007: ENCODE processes one bit per cycle for exactly 8 cycles, i = 0..7, with b = byte[i]:
- p0 = b^s1^s0 (g0 = 111).
- p1 = b^s0 (g1 = 101).
- packet[15-2i] = p0, packet[14-2i] = p1.
- {s1,s0} <= {b,s1}.
- After i = 7 the FSM goes to SEND.
REQ-008: SEND:
- On the first edge where busy_i is sampled low, set dvalid_o = 1 and data_o = packet, and go to IDLE.
- While busy_i is high, stay in SEND with dvalid_o = 0.
REQ-009: dvalid_o SHALL be high for exactly one cycle per packet.
REQ-010: data_o SHALL hold the last issued packet until the next issue.
REQ-011: With an empty, idle block and busy_i low, a byte accepted at edge E SHALL produce dvalid_o high in the cycle following edge E+10. Breakdown: pop at E+1, encode at E+2..E+9, issue at E+10.
REQ-012: Sustained throughput SHALL be one packet per 10 cycles while busy_i stays low.
REQ-013: Encoder state {s1,s0} SHALL persist across bytes; it is not cleared per byte.
REQ-014: flush_i:
- Asserted in IDLE: clears {s1,s0} to 00 at that edge; this takes priority over the state update of a pop on the same edge.
- Asserted in ENCODE or SEND: latched into a pending flag, which is applied, then cleared, on the first IDLE cycle.
- The in-flight packet SHALL be unaffected.
REQ-015: The FIFO SHALL keep accepting pushes during ENCODE and SEND.
REQ-016: busy_i changes during ENCODE SHALL have no effect; busy_i is only sampled in SEND.

Reset
REQ-017: While rst_n is low, the block SHALL force all of the following, regardless of clk:
- FSM = IDLE
- FIFO pointers and level = 0
- {s1,s0} = 00
- pending flush = 0
- dvalid_o = 0
- data_o = 16'h0000
- ready_o = 1
REQ-018: Reset asserted mid-ENCODE or mid-SEND SHALL discard the in-flight packet and all FIFO contents. No dvalid_o pulse SHALL follow the reset release until a new byte is pushed.

Verification
REQ-019: After reset, push 8'h01 with busy_i = 0 -> data_o = 16'hEC00, dvalid_o pulses once, 10 cycles after the accept edge.
REQ-020: After reset, push 8'hFF then 8'h00 -> packets 16'hDAAA then 16'h7000, because state 11 carries over.
REQ-021: Repeat REQ-020 with a flush_i pulse issued while 8'hFF is in ENCODE -> packets 16'hDAAA then 16'h0000.
REQ-022: Hold busy_i = 1 and push 6 bytes back-to-back:
- ready_o drops when the level reaches 4.
- Extra bytes are dropped.
- No dvalid_o while busy_i is high.
- After busy_i falls: exactly 5 packets (1 in SEND plus 4 from the FIFO), 10 cycles apart, in order.
REQ-023: Assert rst_n = 0 mid-ENCODE with 2 bytes queued -> all outputs take their reset values, and no packet follows the release.
REQ-024: Random byte stream, fed through this block into system_top with busy_o -> busy_i -> the decoded bytes equal the input bytes in order, with zero drops while dvalid_i respects ready_o.

Source files
------------

// File: rtl/conv_encoder_tx.sv
// ============================================================================
//  Module   : conv_encoder_tx
//  Purpose  : Rate-1/2, constraint-length-3 convolutional encoder (g0 = 111,
//             g1 = 101) fed from a 4-byte input FIFO. Each byte is encoded
//             LSB first into a 16-bit packet that is handed to a downstream
//             Viterbi decoder once that decoder reports it is not busy.
//  Ports    : clk          - system clock, rising edge
//             rst_n        - asynchronous active-low reset
//             dvalid_i     - input byte valid
//             data_i[7:0]  - input byte (bit 0 encoded first)
//             ready_o      - input FIFO can accept a byte
//             flush_i      - request to return encoder shift state to 00
//             busy_i       - downstream decoder busy, holds packet issue
//             data_o[15:0] - last issued encoded packet
//             dvalid_o     - one-cycle packet strobe
//             fifo_level_o - input FIFO occupancy, 0..4
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dvalid_i,
  input  logic [7:0]  data_i,
  output logic        ready_o,
  input  logic        flush_i,
  input  logic        busy_i,
  output logic [15:0] data_o,
  output logic        dvalid_o,
  output logic [2:0]  fifo_level_o
);

  localparam logic [2:0] C_FIFO_FULL = 3'd4;
  localparam logic [2:0] C_LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_SEND   = 2'd2
  } state_t;

  state_t      r_state;

  // Input FIFO storage and bookkeeping
  logic [7:0]  r_fifo_mem [0:3];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_level;

  // Encoder datapath
  logic [7:0]  r_shift;      // byte being encoded, consumed from bit 0
  logic [2:0]  r_bit_cnt;
  logic [1:0]  r_enc_st;     // {s1, s0}, carried across bytes
  logic        r_flush_pend;
  logic [15:0] r_packet;

  // Registered outputs
  logic [15:0] r_data_o;
  logic        r_dvalid_o;

  logic        w_push;
  logic        w_pop;
  logic        w_bit;
  logic        w_p0;
  logic        w_p1;

  assign ready_o      = (r_level != C_FIFO_FULL);
  assign fifo_level_o = r_level;
  assign data_o       = r_data_o;
  assign dvalid_o     = r_dvalid_o;

  assign w_push = dvalid_i && ready_o;
  assign w_pop  = (r_state == ST_IDLE) && (r_level != 3'd0);

  assign w_bit  = r_shift[0];
  assign w_p0   = w_bit ^ r_enc_st[1] ^ r_enc_st[0];
  assign w_p1   = w_bit ^ r_enc_st[0];

  // FIFO storage needs no reset: contents are only read behind a valid level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_level  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_enc_st     <= 2'b00;
      r_flush_pend <= 1'b0;
      r_packet     <= 16'h0000;
      r_data_o     <= 16'h0000;
      r_dvalid_o   <= 1'b0;
    end else begin
      r_dvalid_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A flush (direct or deferred) wins over nothing here: popping only
          // loads the shift register, so clearing {s1,s0} on the same edge
          // guarantees the popped byte starts from state 00.
          if (flush_i || r_flush_pend) begin
            r_enc_st <= 2'b00;
          end
          r_flush_pend <= 1'b0;
          if (w_pop) begin
            r_shift   <= r_fifo_mem[r_rd_ptr];
            r_bit_cnt <= 3'd0;
            r_state   <= ST_ENCODE;
          end
        end

        ST_ENCODE: begin
          // Defer flushes so the in-flight packet is encoded undisturbed.
          if (flush_i) begin
            r_flush_pend <= 1'b1;
          end
          // Shifting pairs in from the bottom lands bit 0's pair at [15:14]
          // after eight steps.
          r_packet  <= {r_packet[13:0], w_p0, w_p1};
          r_enc_st  <= {w_bit, r_enc_st[1]};
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == C_LAST_BIT) begin
            r_state <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (flush_i) begin
            r_flush_pend <= 1'b1;
          end
          if (!busy_i) begin
            r_dvalid_o <= 1'b1;
            r_data_o   <= r_packet;
            r_state    <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_tx.sv
// ============================================================================
//  Module   : tb_conv_encoder_tx
//  Purpose  : Self-checking bench for conv_encoder_tx. Directed scenarios plus
//             a randomized byte stream compared against a bit-serial
//             convolutional-code reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_encoder_tx;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        dvalid_i = 1'b0;
  logic [7:0]  data_i   = 8'h00;
  logic        flush_i  = 1'b0;
  logic        busy_i   = 1'b0;
  logic        ready_o;
  logic [15:0] data_o;
  logic        dvalid_o;
  logic [2:0]  fifo_level_o;

  always #5 clk = ~clk;

  conv_encoder_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dvalid_i     (dvalid_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .flush_i      (flush_i),
    .busy_i       (busy_i),
    .data_o       (data_o),
    .dvalid_o     (dvalid_o),
    .fifo_level_o (fifo_level_o)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  logic [15:0] last_pkt = 16'h0000;
  logic        prev_dv  = 1'b0;
  logic [15:0] got_pkt[$];
  int          got_cyc[$];
  logic [1:0]  m_state = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference: rate-1/2 code, window {b, s1, s0}, g0 = 111, g1 = 101.
  function automatic logic [15:0] ref_encode(input logic [7:0] b);
    logic [15:0] pkt;
    logic [2:0]  w;
    pkt = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      w = {b[i], m_state};
      pkt[15-2*i] = ^w;
      pkt[14-2*i] = w[2] ^ w[0];
      m_state = w[2:1];
    end
    return pkt;
  endfunction

  // Advance one clock; sample 1 time unit after the edge and log packets.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (dvalid_o) begin
      check("dvalid_single_cycle", 32'(prev_dv), 32'(1'b0));
      got_pkt.push_back(data_o);
      got_cyc.push_back(cyc);
      last_pkt = data_o;
    end else begin
      check("data_o_hold", 32'(data_o), 32'(last_pkt));
    end
    prev_dv = dvalid_o;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dvalid_o"}, 32'(dvalid_o), 32'(1'b0));
    check({tag, "_data_o"}, 32'(data_o), 32'(16'h0000));
    check({tag, "_ready_o"}, 32'(ready_o), 32'(1'b1));
    check({tag, "_level"}, 32'(fifo_level_o), 32'(3'd0));
  endtask

  task automatic apply_reset();
    dvalid_i = 1'b0;
    flush_i  = 1'b0;
    busy_i   = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_values("reset_async");
    last_pkt = 16'h0000;
    prev_dv  = 1'b0;
    step();
    step();
    check_reset_values("reset_held");
    rst_n = 1'b1;
    got_pkt.delete();
    got_cyc.delete();
    m_state = 2'b00;
  endtask

  task automatic drive(input logic v, input logic [7:0] b, output logic acc);
    dvalid_i = v;
    data_i   = b;
    acc      = v && ready_o;
    step();
    dvalid_i = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k;
    k = 0;
    while (got_pkt.size() < n && k < budget) begin
      step();
      k++;
    end
    if (got_pkt.size() < n) check("pulse_timeout", 32'(got_pkt.size()), 32'(n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles required fewer", cyc);
    $fatal(1);
  end

  initial begin
    logic       acc;
    int         e;
    logic [7:0] bytes6[6];
    logic [7:0] exp_b[$];

    // ---------------- single byte, latency and value ----------------
    apply_reset();
    drive(1'b1, 8'h01, acc);
    e = cyc;
    check("t1_accept", 32'(acc), 32'(1'b1));
    check("t1_level_after_push", 32'(fifo_level_o), 32'(3'd1));
    step();
    check("t1_level_after_pop", 32'(fifo_level_o), 32'(3'd0));
    wait_pulses(1, 30);
    if (got_pkt.size() >= 1) begin
      check("t1_data", 32'(got_pkt[0]), 32'(16'hEC00));
      check("t1_latency", 32'(got_cyc[0] - e), 32'(10));
    end
    repeat (15) step();
    check("t1_pulse_count", 32'(got_pkt.size()), 32'(1));

    // ---------------- state carry-over ----------------
    apply_reset();
    drive(1'b1, 8'hFF, acc);
    drive(1'b1, 8'h00, acc);
    wait_pulses(2, 40);
    if (got_pkt.size() >= 2) begin
      check("t2_pkt0", 32'(got_pkt[0]), 32'(16'hDAAA));
      check("t2_pkt1", 32'(got_pkt[1]), 32'(16'h7000));
      check("t2_pkt0_model", 32'(got_pkt[0]), 32'(ref_encode(8'hFF)));
      check("t2_pkt1_model", 32'(got_pkt[1]), 32'(ref_encode(8'h00)));
      check("t2_interval", 32'(got_cyc[1] - got_cyc[0]), 32'(10));
    end

    // ---------------- flush during ENCODE is deferred ----------------
    apply_reset();
    drive(1'b1, 8'hFF, acc);
    drive(1'b1, 8'h00, acc);
    step();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    wait_pulses(2, 40);
    if (got_pkt.size() >= 2) begin
      check("t3_pkt0", 32'(got_pkt[0]), 32'(16'hDAAA));
      check("t3_pkt1", 32'(got_pkt[1]), 32'(16'h0000));
    end

    // ---------------- flush in IDLE on the pop edge ----------------
    apply_reset();
    drive(1'b1, 8'hFF, acc);
    wait_pulses(1, 30);
    repeat (3) step();
    drive(1'b1, 8'h00, acc);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    wait_pulses(2, 30);
    if (got_pkt.size() >= 2) begin
      check("t4_pkt0", 32'(got_pkt[0]), 32'(16'hDAAA));
      check("t4_pkt1_flushed", 32'(got_pkt[1]), 32'(16'h0000));
    end

    // ---------------- busy back-pressure, FIFO full, drops ----------------
    apply_reset();
    busy_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bytes6[i] = 8'($urandom);
      drive(1'b1, bytes6[i], acc);
      check($sformatf("t5_accept%0d", i), 32'(acc), 32'(i < 5));
    end
    check("t5_level_full", 32'(fifo_level_o), 32'(3'd4));
    check("t5_ready_low", 32'(ready_o), 32'(1'b0));
    repeat (30) step();
    check("t5_no_pulse_busy", 32'(got_pkt.size()), 32'(0));
    busy_i = 1'b0;
    wait_pulses(5, 80);
    repeat (20) step();
    check("t5_pulse_count", 32'(got_pkt.size()), 32'(5));
    if (got_pkt.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t5_pkt%0d", i), 32'(got_pkt[i]), 32'(ref_encode(bytes6[i])));
        if (i > 0) check($sformatf("t5_gap%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'(10));
      end
    end

    // ---------------- reset mid-ENCODE with bytes queued ----------------
    apply_reset();
    drive(1'b1, 8'h5A, acc);
    drive(1'b1, 8'hC3, acc);
    drive(1'b1, 8'h3C, acc);
    step();
    step();
    check("t6_level_before_reset", 32'(fifo_level_o), 32'(3'd2));
    apply_reset();
    repeat (40) step();
    check("t6_no_pulse_after_reset", 32'(got_pkt.size()), 32'(0));
    check("t6_level_after_reset", 32'(fifo_level_o), 32'(3'd0));

    // ---------------- randomized stream ----------------
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) < 2) busy_i = ~busy_i;
      drive(1'($urandom_range(0, 1)), 8'($urandom), acc);
      if (acc) exp_b.push_back(data_i);
    end
    busy_i = 1'b0;
    wait_pulses(exp_b.size(), 12 * exp_b.size() + 60);
    repeat (20) step();
    check("t7_pulse_count", 32'(got_pkt.size()), 32'(exp_b.size()));
    check("t7_level_drained", 32'(fifo_level_o), 32'(3'd0));
    if (got_pkt.size() == exp_b.size()) begin
      for (int i = 0; i < exp_b.size(); i++) begin
        check($sformatf("t7_pkt%0d", i), 32'(got_pkt[i]), 32'(ref_encode(exp_b[i])));
        if (i > 0) check($sformatf("t7_gap_ge10_%0d", i),
                         32'(got_cyc[i] - got_cyc[i-1] >= 10), 32'(1'b1));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
